// File: rtl/prm_edge_chk_seq.sv
// rtl/prm_edge_chk_seq.sv - sequential reprogrammable cube-table edge collision checker
//
// Purpose: holds a table of up to NCUBE product terms (care mask + value) and
// answers one NIN-bit query at a time with edge_mask = OR of all matching terms.
// LANES cubes are compared per cycle, and the first matching group ends the scan early.
//
// Optional feature: define PRM_CHK_STATS_EN to add saturating query/hit counters.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/cfg_addr     write one cube (cfg_care, cfg_val); accepted only while idle
//   cfg_len_we/cfg_len  load number of valid cubes (saturates at NCUBE)
//   cfg_ready           high while idle (config is taken this cycle)
//   in_valid/in_ready   query handshake carrying in_vec and in_tag
//   out_valid/out_ready result handshake carrying out_mask and out_tag
//   stat_clr            (PRM_CHK_STATS_EN) zero both counters
//   stat_qry, stat_hit  (PRM_CHK_STATS_EN) results delivered / results with mask=1
module prm_edge_chk_seq #(
  parameter int NIN   = 15,
  parameter int NCUBE = 128,
  parameter int LANES = 4,
  parameter int TAGW  = 8,
  parameter int AW    = $clog2(NCUBE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [NIN-1:0]  cfg_care,
  input  logic [NIN-1:0]  cfg_val,
  input  logic            cfg_len_we,
  input  logic [AW:0]     cfg_len,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NIN-1:0]  in_vec,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_mask,
  output logic [TAGW-1:0] out_tag
`ifdef PRM_CHK_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_qry,
  output logic [31:0]     stat_hit
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [NIN-1:0]  care_mem [NCUBE];
  logic [NIN-1:0]  val_mem  [NCUBE];
  logic [AW:0]     len;
  logic [AW:0]     idx;
  logic [AW:0]     idx_nxt;
  logic [NIN-1:0]  q_vec;
  logic [TAGW-1:0] q_tag;
  logic [LANES-1:0] lane_hit;
  logic            in_fire;
  logic            out_fire;

  assign cfg_ready = (state == IDLE);
  // Config writes take priority over a query in the same cycle.
  assign in_ready  = (state == IDLE) && !rst && !cfg_we && !cfg_len_we;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = (state == DONE) && out_ready;
  // idx stays below len <= NCUBE, so one extra bit keeps idx + LANES from wrapping.
  assign idx_nxt   = idx + (AW+1)'(LANES);

  // Lanes past len are masked off so stale table entries never contribute.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [AW:0] lidx;
    assign lidx = idx + (AW+1)'(g);
    assign lane_hit[g] = (lidx < len) &&
                         (((q_vec ^ val_mem[lidx[AW-1:0]]) & care_mem[lidx[AW-1:0]]) == '0);
  end

  // Table is deliberately not reset so a reset mid-query keeps the programmed cubes.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      care_mem[cfg_addr] <= cfg_care;
      val_mem[cfg_addr]  <= cfg_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      q_vec     <= '0;
      q_tag     <= '0;
      out_valid <= 1'b0;
      out_mask  <= 1'b0;
      out_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_len_we)
            len <= (cfg_len > (AW+1)'(NCUBE)) ? (AW+1)'(NCUBE) : cfg_len;
          if (in_fire) begin
            q_vec <= in_vec;
            q_tag <= in_tag;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (|lane_hit) begin
            out_mask  <= 1'b1;
            out_tag   <= q_tag;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (idx_nxt >= len) begin
            out_mask  <= 1'b0;
            out_tag   <= q_tag;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx_nxt;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PRM_CHK_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_qry <= '0;
      stat_hit <= '0;
    end else if (stat_clr) begin
      stat_qry <= '0;
      stat_hit <= '0;
    end else if (out_fire) begin
      if (stat_qry != '1)
        stat_qry <= stat_qry + 32'd1;
      if (out_mask && stat_hit != '1)
        stat_hit <= stat_hit + 32'd1;
    end
  end
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_prm_edge_chk_seq.sv
// tb/tb_prm_edge_chk_seq.sv - scoreboard bench for prm_edge_chk_seq
module tb_prm_edge_chk_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [6:0]  cfg_addr = '0;
  logic [14:0] cfg_care = '0;
  logic [14:0] cfg_val = '0;
  logic        cfg_len_we = 1'b0;
  logic [7:0]  cfg_len = '0;
  logic        cfg_ready;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_vec = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_mask;
  logic [7:0]  out_tag;
`ifdef PRM_CHK_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_qry;
  logic [31:0] stat_hit;
`endif

  prm_edge_chk_seq dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_tag(out_tag)
`ifdef PRM_CHK_STATS_EN
    , .stat_clr(stat_clr), .stat_qry(stat_qry), .stat_hit(stat_hit)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       m;
    logic [7:0] t;
    int         lat;
    int         hs;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  // Monitor: each new result is compared against the oldest expectation.
  initial begin : monitor
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          check("res_mask", 32'(out_mask), 32'(e.m));
          check("res_tag", 32'(out_tag), 32'(e.t));
          check("res_latency", 32'(cyc - e.hs), 32'(e.lat));
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic cfg_write(input logic [6:0] a, input logic [14:0] c, input logic [14:0] v);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_care = c; cfg_val = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic set_len(input logic [7:0] l);
    @(negedge clk);
    cfg_len_we = 1'b1; cfg_len = l;
    @(posedge clk); #1;
    cfg_len_we = 1'b0;
  endtask

  task automatic query(input logic [14:0] v, input logic [7:0] t, input logic m,
                       input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    in_vec = v; in_tag = t; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("query_accept");
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back('{m, t, lat, cyc});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) fail_now("drain");
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("wait_valid");
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_mask", 32'(out_mask), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // len=0 after reset: one scan cycle, no match
    query(15'h1234, 8'd1, 1'b0, 2, 1'b1);
    drain();

    // T1/T2: single full-care cube
    cfg_write(7'd0, 15'h7FFF, 15'h5A5A);
    set_len(8'd1);
    query(15'h5A5A, 8'd3, 1'b1, 2, 1'b1);
    query(15'h5A5B, 8'd4, 1'b0, 2, 1'b1);
    drain();

    // T3: only cube 127 matches 0x4000, full table
    for (int i = 0; i < 127; i++) cfg_write(7'(i), 15'h7FFF, 15'h0000);
    cfg_write(7'd127, 15'h4000, 15'h4000);
    set_len(8'd128);
    query(15'h4000, 8'd5, 1'b1, 33, 1'b1);
    query(15'h0001, 8'd6, 1'b0, 33, 1'b1);
    drain();

    // Simultaneous cube write and len load; len 255 saturates to 128
    set_len(8'd8);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 7'd3; cfg_care = 15'h0001; cfg_val = 15'h0001;
    cfg_len_we = 1'b1; cfg_len = 8'd255;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_len_we = 1'b0;
    query(15'h0001, 8'd8, 1'b1, 2, 1'b1);
    query(15'h4000, 8'd9, 1'b1, 33, 1'b1);
    drain();
    cfg_write(7'd3, 15'h7FFF, 15'h0000);

    // Early exit on cube 2
    cfg_write(7'd2, 15'h4000, 15'h4000);
    query(15'h4000, 8'd10, 1'b1, 2, 1'b1);
    drain();
    cfg_write(7'd2, 15'h7FFF, 15'h0000);

    // Partial last group: cube 6 matches everything but lies beyond len=6
    cfg_write(7'd6, 15'h0000, 15'h0000);
    set_len(8'd6);
    query(15'h0001, 8'd11, 1'b0, 3, 1'b1);
    drain();
    set_len(8'd7);
    query(15'h0001, 8'd12, 1'b1, 3, 1'b1);
    drain();
    cfg_write(7'd6, 15'h7FFF, 15'h0000);
    set_len(8'd128);

    // T4: hold in DONE, config attempts dropped
    out_ready = 1'b0;
    query(15'h4000, 8'd20, 1'b1, 33, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_mask", 32'(out_mask), 32'd1);
      check("hold_tag", 32'(out_tag), 32'd20);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_cfg_ready", 32'(cfg_ready), 32'd0);
      if (i == 3) begin
        cfg_we = 1'b1; cfg_addr = 7'd127; cfg_care = 15'h7FFF; cfg_val = 15'h0000;
        cfg_len_we = 1'b1; cfg_len = 8'd0;
      end else begin
        cfg_we = 1'b0; cfg_len_we = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    query(15'h4000, 8'd21, 1'b1, 33, 1'b1);
    drain();

    // T5: reset during scan cycle 5
    query(15'h4000, 8'd22, 1'b1, 33, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_mask", 32'(out_mask), 32'd0);
    check("abort_out_tag", 32'(out_tag), 32'd0);
    check("abort_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_len(8'd128);
    query(15'h4000, 8'd23, 1'b1, 33, 1'b1);
    query(15'h0002, 8'd24, 1'b0, 33, 1'b1);
    drain();

`ifdef PRM_CHK_STATS_EN
    // T6: counters
    @(negedge clk);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check("stat_clr_qry", stat_qry, 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) query(15'h4000, 8'(30 + i), 1'b1, 33, 1'b1);
      else       query(15'h0001, 8'(30 + i), 1'b0, 33, 1'b1);
    end
    drain();
    check("stat_qry", stat_qry, 32'd6);
    check("stat_hit", stat_hit, 32'd4);
    out_ready = 1'b0;
    query(15'h4000, 8'd40, 1'b1, 33, 1'b1);
    wait_valid();
    @(negedge clk);
    stat_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    drain();
    check("stat_clr_win_qry", stat_qry, 32'd0);
    check("stat_clr_win_hit", stat_hit, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
